// File: rtl/dds_pkg.sv
// Shared widths, levels and state encoding for the DDS frequency meter.
package dds_pkg;

  localparam int SINE_W   = 14;
  localparam int KW_W     = 32;
  localparam int MIDSCALE = 8192;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_e;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Sample/control bundle between a DDS sample source and the frequency meter.
interface dds_freq_meter_if;
  import dds_pkg::*;

  logic [SINE_W-1:0] Sine;
  logic              start;
  logic [KW_W-1:0]   KW_est;
  logic              busy;
  logic              done;
  logic              no_signal;

  modport master (
    output Sine,
    output start,
    input  KW_est,
    input  busy,
    input  done,
    input  no_signal
  );

  modport slave (
    input  Sine,
    input  start,
    output KW_est,
    output busy,
    output done,
    output no_signal
  );

endinterface

// File: rtl/dds_hyst_squarer.sv
// Schmitt-trigger squarer for offset-binary samples. sq_o is the registered
// sign with hysteresis; rc_o flags a rising crossing in the same cycle the
// sample meets the upper threshold.
module dds_hyst_squarer
  import dds_pkg::*;
#(
  parameter int HYST      = 64,
  parameter int MID_LEVEL = MIDSCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SINE_W-1:0] sine_i,
  output logic              sq_o,
  output logic              rc_o
);

  localparam logic [SINE_W-1:0] THR_HI = SINE_W'(MID_LEVEL + HYST);
  localparam logic [SINE_W-1:0] THR_LO = SINE_W'(MID_LEVEL - HYST - 1);

  logic sq_q, sq_d;

  // Samples inside the band (THR_LO, THR_HI) leave the square wave untouched.
  always_comb begin
    sq_d = sq_q;
    if (sine_i >= THR_HI) begin
      sq_d = 1'b1;
    end else if (sine_i <= THR_LO) begin
      sq_d = 1'b0;
    end
  end

  // Square-wave state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
  assign rc_o = sq_d & ~sq_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Recovers a DDS tuning word by counting rising crossings over a 2^GATE_LOG2
// clock gate that opens on the first crossing after start.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start
//   ARM     | waiting for the first rising crossing, timeout after gate
//   MEASURE | counting crossings over the gate following the arming edge
//   DONE    | one-cycle result strobe, start ignored
module dds_freq_meter #(
  parameter int GATE_LOG2 = 16,
  parameter int HYST      = 64,
  parameter int MIDSCALE  = 8192
) (
  input logic             clk,
  input logic             rst_n,
  dds_freq_meter_if.slave bus
);
  import dds_pkg::*;

  state_e               state_q, state_d;
  logic [GATE_LOG2-1:0] timer_q, timer_d;
  logic [GATE_LOG2:0]   count_q, count_d;
  logic [GATE_LOG2:0]   count_sat;
  logic [GATE_LOG2:0]   count_meas;
  logic [KW_W-1:0]      kw_q, kw_d;
  logic                 nosig_q, nosig_d;
  logic                 busy_q, done_q;
  logic                 rc;
  logic                 sq_unused;

  dds_hyst_squarer #(
    .HYST      (HYST),
    .MID_LEVEL (MIDSCALE)
  ) u_squarer (
    .clk    (clk),
    .rst_n  (rst_n),
    .sine_i (bus.Sine),
    .sq_o   (sq_unused),
    .rc_o   (rc)
  );

  assign count_sat  = (count_q == '1) ? count_q : count_q + 1'b1;
  assign count_meas = rc ? count_sat : count_q;

  // Next-state and result computation; the timer is a down-counter loaded
  // with 2^GATE_LOG2-1 so terminal count zero marks the last gate cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    kw_d    = kw_q;
    nosig_d = nosig_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          timer_d = '1;
        end
      end
      ARM: begin
        if (rc) begin
          state_d = MEASURE;
          timer_d = '1;
          count_d = '0;
        end else if (timer_q == '0) begin
          state_d = DONE;
          kw_d    = '0;
          nosig_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEASURE: begin
        count_d = count_meas;
        if (timer_q == '0) begin
          state_d = DONE;
          kw_d    = KW_W'(count_meas) << (KW_W - GATE_LOG2);
          nosig_d = (count_meas == '0);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      kw_q    <= '0;
      nosig_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      kw_q    <= kw_d;
      nosig_q <= nosig_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.KW_est    = kw_q;
  assign bus.no_signal = nosig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
